// File: rtl/comm_transmitter.sv
// Serial frame transmitter toward the MCU: start bit, MSB-first payload, even parity, stop and gap.
// The bit period is derived from the pixel clock frequency selected for each frame.
module comm_transmitter #(
  parameter int unsigned PACKET_BITS = 8,
  parameter int unsigned CLK_FREQ0   = 74250000,
  parameter int unsigned CLK_FREQ1   = 74175824,
  parameter int unsigned US_BIT      = 10
) (
  input  logic                   pxlClk,
  input  logic                   rst,
  input  logic                   clkFreq,
  input  logic [PACKET_BITS-1:0] txData,
  input  logic                   txValid,
  output logic                   txReady,
  output logic                   serOut,
  output logic                   busy,
  output logic                   txDone
);

  // Bit period in clock cycles, rounded to the nearest cycle.
  localparam int unsigned BIT_CYC0 =
    32'((64'(CLK_FREQ0) * 64'(US_BIT) + 64'd500000) / 64'd1000000);
  localparam int unsigned BIT_CYC1 =
    32'((64'(CLK_FREQ1) * 64'(US_BIT) + 64'd500000) / 64'd1000000);
  localparam int unsigned BIT_CYC_MAX = (BIT_CYC0 > BIT_CYC1) ? BIT_CYC0 : BIT_CYC1;
  localparam int unsigned CNT_W = (BIT_CYC_MAX > 1) ? $clog2(BIT_CYC_MAX) : 1;
  localparam int unsigned BIT_W = $clog2(PACKET_BITS + 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;
  localparam logic [2:0] GAP    = 3'd5;

  logic [2:0]             state, stateNext;
  logic [CNT_W-1:0]       cycCnt, cycCntNext;
  logic [BIT_W-1:0]       bitCnt, bitCntNext;
  logic [PACKET_BITS-1:0] shiftReg, shiftNext;
  logic                   parityBit, parityNext;
  logic                   freqSel, freqNext;
  logic                   serOutNext, txReadyNext, busyNext, txDoneNext;
  logic [CNT_W-1:0]       lastCyc;
  logic                   bitEnd;

  // Divisor follows the frequency latched with the payload, not the live input.
  assign lastCyc = freqSel ? CNT_W'(BIT_CYC1 - 1) : CNT_W'(BIT_CYC0 - 1);
  assign bitEnd  = (cycCnt == lastCyc);

  // Next-state and next-output logic.
  always_comb begin
    stateNext   = state;
    cycCntNext  = cycCnt;
    bitCntNext  = bitCnt;
    shiftNext   = shiftReg;
    parityNext  = parityBit;
    freqNext    = freqSel;
    serOutNext  = serOut;
    txReadyNext = txReady;
    busyNext    = busy;
    txDoneNext  = 1'b0;

    if (state != IDLE) begin
      cycCntNext = bitEnd ? '0 : cycCnt + CNT_W'(1);
    end

    case (state)
      IDLE: begin
        serOutNext  = 1'b1;
        busyNext    = 1'b0;
        txReadyNext = 1'b1;
        if (txReady && txValid) begin
          stateNext   = START;
          shiftNext   = txData;
          parityNext  = ^txData;
          freqNext    = clkFreq;
          cycCntNext  = '0;
          bitCntNext  = '0;
          serOutNext  = 1'b0;
          txReadyNext = 1'b0;
          busyNext    = 1'b1;
        end
      end
      START: begin
        if (bitEnd) begin
          stateNext  = DATA;
          serOutNext = shiftReg[PACKET_BITS-1];
          shiftNext  = shiftReg << 1;
          bitCntNext = BIT_W'(1);
        end
      end
      DATA: begin
        if (bitEnd) begin
          if (bitCnt == BIT_W'(PACKET_BITS)) begin
            stateNext  = PARITY;
            serOutNext = parityBit;
          end else begin
            serOutNext = shiftReg[PACKET_BITS-1];
            shiftNext  = shiftReg << 1;
            bitCntNext = bitCnt + BIT_W'(1);
          end
        end
      end
      PARITY: begin
        if (bitEnd) begin
          stateNext  = STOP;
          serOutNext = 1'b1;
        end
      end
      STOP: begin
        if (bitEnd) begin
          stateNext  = GAP;
          serOutNext = 1'b1;
        end
      end
      GAP: begin
        if (bitEnd) begin
          stateNext   = IDLE;
          serOutNext  = 1'b1;
          busyNext    = 1'b0;
          txReadyNext = 1'b1;
          txDoneNext  = 1'b1;
        end
      end
      default: begin
        stateNext   = IDLE;
        serOutNext  = 1'b1;
        busyNext    = 1'b0;
        txReadyNext = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge pxlClk) begin
    if (rst) begin
      state     <= IDLE;
      cycCnt    <= '0;
      bitCnt    <= '0;
      shiftReg  <= '0;
      parityBit <= 1'b0;
      freqSel   <= 1'b0;
      serOut    <= 1'b1;
      txReady   <= 1'b0;
      busy      <= 1'b0;
      txDone    <= 1'b0;
    end else begin
      state     <= stateNext;
      cycCnt    <= cycCntNext;
      bitCnt    <= bitCntNext;
      shiftReg  <= shiftNext;
      parityBit <= parityNext;
      freqSel   <= freqNext;
      serOut    <= serOutNext;
      txReady   <= txReadyNext;
      busy      <= busyNext;
      txDone    <= txDoneNext;
    end
  end

endmodule

// File: tb/tb_comm_transmitter.sv
// Bench for comm_transmitter: one instance at default timing, one with a short bit period,
// both tracked cycle by cycle against a waveform-queue model.
module tb_comm_transmitter;

  localparam int unsigned PB = 8;

  logic pxlClk = 1'b0;
  always #5 pxlClk = ~pxlClk;

  logic [1:0]    rstV, txValidV, clkFreqV;
  logic [PB-1:0] txDataV [2];
  logic          serOut0, serOut1, txReady0, txReady1, busy0, busy1, txDone0, txDone1;
  logic [1:0]    serOutV, txReadyV, busyV, txDoneV;

  assign serOutV  = {serOut1, serOut0};
  assign txReadyV = {txReady1, txReady0};
  assign busyV    = {busy1, busy0};
  assign txDoneV  = {txDone1, txDone0};

  comm_transmitter #(.PACKET_BITS(PB)) dutD (
    .pxlClk(pxlClk), .rst(rstV[0]), .clkFreq(clkFreqV[0]), .txData(txDataV[0]),
    .txValid(txValidV[0]), .txReady(txReady0), .serOut(serOut0), .busy(busy0), .txDone(txDone0));

  comm_transmitter #(.PACKET_BITS(PB), .CLK_FREQ0(4500000), .CLK_FREQ1(3400000), .US_BIT(1)) dutS (
    .pxlClk(pxlClk), .rst(rstV[1]), .clkFreq(clkFreqV[1]), .txData(txDataV[1]),
    .txValid(txValidV[1]), .txReady(txReady1), .serOut(serOut1), .busy(busy1), .txDone(txDone1));

  int checks = 0;
  int errors = 0;
  bit monEn  = 1'b0;

  // Cycles per bit for each instance, straight from the rounding rule.
  function automatic int bitCyc(int d, bit f);
    longint unsigned freq, us;
    if (d == 0) begin
      freq = f ? 64'd74175824 : 64'd74250000;
      us   = 64'd10;
    end else begin
      freq = f ? 64'd3400000 : 64'd4500000;
      us   = 64'd1;
    end
    return int'((freq * us + 64'd500000) / 64'd1000000);
  endfunction

  // Model: on acceptance the whole expected line waveform is queued and then replayed.
  bit mWave [2][$];
  bit mSer [2];
  bit mReady [2];
  bit mBusy [2];
  bit mDone [2];

  function automatic void buildFrame(int d, logic [PB-1:0] data, bit f);
    int bc;
    bit v;
    bc = bitCyc(d, f);
    for (int b = 0; b < int'(PB) + 4; b++) begin
      if (b == 0) v = 1'b0;
      else if (b <= int'(PB)) v = data[int'(PB) - b];
      else if (b == int'(PB) + 1) v = ^data;
      else v = 1'b1;
      repeat (bc) mWave[d].push_back(v);
    end
  endfunction

  always @(posedge pxlClk) begin
    for (int d = 0; d < 2; d++) begin
      if (rstV[d] === 1'b1) begin
        mWave[d].delete();
        mSer[d] = 1'b1; mReady[d] = 1'b0; mBusy[d] = 1'b0; mDone[d] = 1'b0;
      end else begin
        mDone[d] = 1'b0;
        if (mBusy[d]) begin
          if (mWave[d].size() > 0) mSer[d] = mWave[d].pop_front();
          else begin
            mBusy[d] = 1'b0; mReady[d] = 1'b1; mDone[d] = 1'b1; mSer[d] = 1'b1;
          end
        end else if (mReady[d] && txValidV[d] === 1'b1) begin
          buildFrame(d, txDataV[d], clkFreqV[d]);
          mSer[d] = mWave[d].pop_front();
          mBusy[d] = 1'b1; mReady[d] = 1'b0;
        end else begin
          mReady[d] = 1'b1; mSer[d] = 1'b1;
        end
      end
    end
  end

  always @(negedge pxlClk) begin
    if (monEn) begin
      for (int d = 0; d < 2; d++) begin
        checks++;
        if ({serOutV[d], txReadyV[d], busyV[d], txDoneV[d]} !== {mSer[d], mReady[d], mBusy[d], mDone[d]}) begin
          errors++;
          $display("FAIL model dut%0d t=%0t ser/rdy/busy/done got %b%b%b%b want %b%b%b%b", d, $time,
                   serOutV[d], txReadyV[d], busyV[d], txDoneV[d], mSer[d], mReady[d], mBusy[d], mDone[d]);
        end
      end
      if (errors > 100) begin
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
    end
  end

  task automatic expect1(string name, logic got, logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %b want %b", name, got, want);
    end
  endtask

  task automatic expectInt(string name, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  // Leaves the caller at a falling edge where txReady is high (transfer on the next rising edge).
  task automatic waitReady(int d);
    int w;
    w = 0;
    while (txReadyV[d] !== 1'b1 && w < 20000) begin
      @(negedge pxlClk);
      w++;
    end
    expect1($sformatf("dut%0d ready wait", d), txReadyV[d], 1'b1);
  endtask

  typedef struct {
    int          d;
    logic [7:0]  data;
    bit          f;
    logic [11:0] exp;      // start, data MSB first, parity, stop, gap
    int          lat;      // acceptance edge to txDone cycle
    int          toggleAt; // frame cycle at which clkFreq flips (0 = never)
    int          pulseAt;  // frame cycle of a one-cycle 0xFF request (0 = never)
  } vec_t;

  vec_t vecs [10];

  task automatic runVec(vec_t v);
    int bc, doneAt, b;
    bc = bitCyc(v.d, v.f);
    txDataV[v.d]  = v.data;
    clkFreqV[v.d] = v.f;
    txValidV[v.d] = 1'b1;
    waitReady(v.d);
    doneAt = 0;
    for (int n = 1; n <= v.lat; n++) begin
      @(negedge pxlClk);
      if (n == 1) txValidV[v.d] = 1'b0;
      if (n == v.toggleAt) clkFreqV[v.d] = ~clkFreqV[v.d];
      if (n == v.pulseAt) begin
        txValidV[v.d] = 1'b1;
        txDataV[v.d]  = '1;
      end
      if (v.pulseAt != 0 && n == v.pulseAt + 1) txValidV[v.d] = 1'b0;
      if (n <= (int'(PB) + 4) * bc && ((n - 1) % bc == 0 || n % bc == 0)) begin
        b = (n - 1) / bc;
        expect1($sformatf("dut%0d data %02h bit%0d cycle%0d", v.d, v.data, b, n),
                serOutV[v.d], v.exp[11 - b]);
      end
      if (doneAt == 0 && txDoneV[v.d] === 1'b1) doneAt = n;
    end
    expectInt($sformatf("dut%0d data %02h txDone latency", v.d, v.data), doneAt, v.lat);
  endtask

  initial begin
    int w;
    vec_t rv;

    vecs[0] = '{0, 8'hA5, 1'b0, 12'b0_10100101_0_11, 8917, 0, 0};
    vecs[1] = '{0, 8'h07, 1'b1, 12'b0_00000111_1_11, 8905, 0, 0};
    vecs[2] = '{1, 8'h3C, 1'b0, 12'b0_00111100_0_11, 61, 0, 0};
    vecs[3] = '{1, 8'hC3, 1'b1, 12'b0_11000011_0_11, 37, 0, 0};
    vecs[4] = '{1, 8'h80, 1'b0, 12'b0_10000000_1_11, 61, 0, 0};
    vecs[5] = '{1, 8'h01, 1'b1, 12'b0_00000001_1_11, 37, 0, 0};
    vecs[6] = '{1, 8'h96, 1'b0, 12'b0_10010110_0_11, 61, 15, 0};
    vecs[7] = '{1, 8'h69, 1'b1, 12'b0_01101001_0_11, 37, 0, 0};
    vecs[8] = '{1, 8'h00, 1'b0, 12'b0_00000000_0_11, 61, 0, 47};
    vecs[9] = '{1, 8'h5A, 1'b1, 12'b0_01011010_0_11, 37, 0, 0};

    rstV = 2'b11; txValidV = 2'b00; clkFreqV = 2'b00;
    txDataV[0] = '0; txDataV[1] = '0;
    repeat (3) @(negedge pxlClk);
    for (int d = 0; d < 2; d++) begin
      expect1($sformatf("dut%0d reset serOut", d), serOutV[d], 1'b1);
      expect1($sformatf("dut%0d reset txReady", d), txReadyV[d], 1'b0);
      expect1($sformatf("dut%0d reset busy", d), busyV[d], 1'b0);
      expect1($sformatf("dut%0d reset txDone", d), txDoneV[d], 1'b0);
    end
    monEn = 1'b1;
    rstV  = 2'b00;
    @(negedge pxlClk);
    expect1("dut0 ready after reset", txReadyV[0], 1'b1);
    expect1("dut1 ready after reset", txReadyV[1], 1'b1);

    for (int i = 0; i < 10; i++) begin
      runVec(vecs[i]);
      if (vecs[i].pulseAt != 0) begin
        repeat (3) @(negedge pxlClk);
        expect1("request during parity not queued", busyV[vecs[i].d], 1'b0);
      end
    end

    // Back-to-back with txValid held high.
    txDataV[1] = 8'h3C; clkFreqV[1] = 1'b0; txValidV[1] = 1'b1;
    waitReady(1);
    @(negedge pxlClk);
    w = 1;
    while (txDoneV[1] !== 1'b1 && w < 200) begin
      @(negedge pxlClk);
      w++;
    end
    expectInt("b2b first latency", w, 61);
    txDataV[1] = 8'hC3;
    @(negedge pxlClk);
    expect1("b2b start bit", serOutV[1], 1'b0);
    expect1("b2b busy", busyV[1], 1'b1);
    txValidV[1] = 1'b0;
    w = 1;
    while (txDoneV[1] !== 1'b1 && w < 200) begin
      @(negedge pxlClk);
      w++;
    end
    expectInt("b2b second latency", w, 61);

    // Reset pulse during the fourth data bit, then a clean 0x55 frame.
    @(negedge pxlClk);
    txDataV[1] = 8'hA5; clkFreqV[1] = 1'b0; txValidV[1] = 1'b1;
    waitReady(1);
    @(negedge pxlClk);
    txValidV[1] = 1'b0;
    repeat (22) @(negedge pxlClk);
    rstV[1] = 1'b1;
    @(negedge pxlClk);
    expect1("mid-frame rst serOut", serOutV[1], 1'b1);
    expect1("mid-frame rst txReady", txReadyV[1], 1'b0);
    expect1("mid-frame rst busy", busyV[1], 1'b0);
    expect1("mid-frame rst txDone", txDoneV[1], 1'b0);
    rstV[1] = 1'b0; txDataV[1] = 8'h55; txValidV[1] = 1'b1;
    @(negedge pxlClk);
    expect1("ready after rst release", txReadyV[1], 1'b1);
    rv = '{1, 8'h55, 1'b0, 12'b0_01010101_0_11, 61, 0, 0};
    runVec(rv);

    // Random traffic on the short-period instance; the model checks every cycle.
    for (int c = 0; c < 4000; c++) begin
      @(negedge pxlClk);
      rstV[1]     = ($urandom_range(0, 599) == 0);
      txValidV[1] = ($urandom_range(0, 3) == 0);
      txDataV[1]  = PB'($urandom);
      clkFreqV[1] = 1'($urandom_range(0, 1));
    end
    @(negedge pxlClk);
    rstV[1] = 1'b0; txValidV[1] = 1'b0;
    repeat (80) @(negedge pxlClk);
    expect1("random drain idle busy", busyV[1], 1'b0);
    expect1("random drain idle serOut", serOutV[1], 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
